// File: rtl/shift_normalizer_32_pkg.sv
// Shared definitions for the sequential 32-bit normalizer: FSM states,
// per-stage shift amounts and mode encodings.
package shift_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S16  = 3'd1,
    S8   = 3'd2,
    S4   = 3'd3,
    S2   = 3'd4,
    S1   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [4:0] STEP_16 = 5'd16;
  localparam logic [4:0] STEP_8  = 5'd8;
  localparam logic [4:0] STEP_4  = 5'd4;
  localparam logic [4:0] STEP_2  = 5'd2;
  localparam logic [4:0] STEP_1  = 5'd1;

  localparam logic NORM_UNSIGNED = 1'b0;
  localparam logic NORM_SIGNED   = 1'b1;

endpackage

// File: rtl/shift_normalizer_32_stage.sv
// One binary-search step of the normalizer: shifts v left by K when the top
// bits are redundant (leading zeros, or copies of the sign bit).
module normalize_stage
  import shift_pkg::*;
#(
  parameter int K = 16
) (
  input  logic [31:0] v,
  input  logic        m,
  output logic [31:0] v_next,
  output logic        take
);

  logic [K-1:0] w_top;
  logic [K:0]   w_sign;

  assign w_top  = v[31:32-K];
  assign w_sign = v[31:31-K];

  // Signed mode inspects K+1 bits so that one copy of the sign survives.
  always_comb begin
    take = 1'b0;
    if (m == NORM_SIGNED) begin
      take = (w_sign == {(K+1){1'b0}}) || (w_sign == {(K+1){1'b1}});
    end else begin
      take = (w_top == {K{1'b0}});
    end
    v_next = take ? (v << K) : v;
  end

endmodule

// File: rtl/shift_normalizer_32.sv
// Sequential 32-bit normalizer: 16/8/4/2/1 binary search, one step per clock,
// returning the normalized value and the left-shift amount applied.
module shift_normalizer_32
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic        c,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic [4:0]  count,
  output logic        zero
);

  state_t      r_state;
  logic [31:0] r_v;
  logic        r_m;
  logic [4:0]  r_cnt;
  logic        r_zero_cap;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_z;
  logic [4:0]  r_count;
  logic        r_zero;

  logic [31:0] w_stage_v    [5];
  logic        w_stage_take [5];
  logic [31:0] w_v_next;
  logic        w_take;
  logic [4:0]  w_amt;
  logic [4:0]  w_cnt_next;
  state_t      w_state_next;

  genvar g;
  generate
    for (g = 0; g < 5; g++) begin : g_stage
      normalize_stage #(.K(16 >> g)) u_stage (
        .v      (r_v),
        .m      (r_m),
        .v_next (w_stage_v[g]),
        .take   (w_stage_take[g])
      );
    end
  endgenerate

  // The current state selects which step's result feeds the shared accumulator.
  always_comb begin
    w_v_next     = r_v;
    w_take       = 1'b0;
    w_amt        = 5'd0;
    w_state_next = IDLE;
    case (r_state)
      S16: begin
        w_v_next = w_stage_v[0]; w_take = w_stage_take[0]; w_amt = STEP_16; w_state_next = S8;
      end
      S8: begin
        w_v_next = w_stage_v[1]; w_take = w_stage_take[1]; w_amt = STEP_8; w_state_next = S4;
      end
      S4: begin
        w_v_next = w_stage_v[2]; w_take = w_stage_take[2]; w_amt = STEP_4; w_state_next = S2;
      end
      S2: begin
        w_v_next = w_stage_v[3]; w_take = w_stage_take[3]; w_amt = STEP_2; w_state_next = S1;
      end
      S1: begin
        w_v_next = w_stage_v[4]; w_take = w_stage_take[4]; w_amt = STEP_1; w_state_next = DONE;
      end
      default: begin
        w_v_next     = r_v;
        w_take       = 1'b0;
        w_amt        = 5'd0;
        w_state_next = IDLE;
      end
    endcase
    w_cnt_next = r_cnt + (w_take ? w_amt : 5'd0);
  end

  // FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_v        <= 32'd0;
      r_m        <= NORM_UNSIGNED;
      r_cnt      <= 5'd0;
      r_zero_cap <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_z        <= 32'd0;
      r_count    <= 5'd0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_v        <= a;
            r_m        <= c;
            r_cnt      <= 5'd0;
            r_zero_cap <= (a == 32'd0);
            r_busy     <= 1'b1;
            r_state    <= S16;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        S16, S8, S4, S2: begin
          r_v     <= w_v_next;
          r_cnt   <= w_cnt_next;
          r_state <= w_state_next;
        end
        S1: begin
          r_v     <= w_v_next;
          r_cnt   <= w_cnt_next;
          r_z     <= w_v_next;
          r_count <= w_cnt_next;
          r_zero  <= r_zero_cap;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign z     = r_z;
  assign count = r_count;
  assign zero  = r_zero;

endmodule

// File: tb/tb_shift_normalizer_32.sv
// Scoreboard bench for shift_normalizer_32: directed corner cases, handshake
// and reset scenarios, then a randomized sweep against a reference model.
module tb_shift_normalizer_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic        c;
  logic        busy;
  logic        done;
  logic [31:0] z;
  logic [4:0]  count;
  logic        zero;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  count;
    logic        zero;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  shift_normalizer_32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .count (count),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count the redundant leading bits directly, cap at 31.
  function automatic exp_t model(input logic [31:0] av, input logic cv);
    exp_t e;
    int   n;
    n = 0;
    if (cv == 1'b0) begin
      for (int i = 31; i >= 0; i--) begin
        if (av[i] == 1'b0) n++;
        else break;
      end
    end else begin
      for (int i = 30; i >= 0; i--) begin
        if (av[i] == av[31]) n++;
        else break;
      end
    end
    if (n > 31) n = 31;
    e.count = n[4:0];
    e.z     = av << n;
    e.zero  = (av == 32'd0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("z", z, e.z);
        chk("count", {27'd0, count}, {27'd0, e.count});
        chk("zero", {31'd0, zero}, {31'd0, e.zero});
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic cv, input exp_t e);
    q.push_back(e);
    a     = av;
    c     = cv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    c     = 1'(($urandom));
  endtask

  task automatic wait_done(input int exp_lat, output int when);
    int i;
    bit found;
    found = 1'b0;
    when  = -1;
    for (i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        found = 1'b1;
        when  = cyc;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within 12 cycles, expected done after %0d", exp_lat);
    end else begin
      chk("latency", i, exp_lat);
    end
  endtask

  task automatic run_dir(input logic [31:0] av, input logic cv,
                         input logic [31:0] ez, input logic [4:0] ec, input logic ezero);
    exp_t e;
    int   t;
    e.z = ez; e.count = ec; e.zero = ezero;
    issue(av, cv, e);
    wait_done(5, t);
  endtask

  initial begin
    exp_t e;
    int   t1, t2;
    logic [31:0] av;
    logic        cv;

    rst = 1'b1; start = 1'b0; a = 32'd0; c = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);

    // Directed corner cases
    run_dir(32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    run_dir(32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0);
    run_dir(32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0);
    run_dir(32'hFFFF_8000, 1'b1, 32'h8000_0000, 5'd16, 1'b0);
    run_dir(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0);
    run_dir(32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1);
    run_dir(32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1);
    run_dir(32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0);
    run_dir(32'hBFFF_0000, 1'b1, 32'hBFFF_0000, 5'd0,  1'b0);
    run_dir(32'h4000_1234, 1'b1, 32'h4000_1234, 5'd0,  1'b0);

    // Start re-pulsed during S8 must be ignored
    repeat (2) begin @(posedge clk); #1; end
    e.z = 32'hC000_0000; e.count = 5'd8; e.zero = 1'b0;
    issue(32'h00C0_0000, 1'b0, e);
    @(posedge clk); #1;
    a = 32'h0000_0003; c = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, t1);

    // Back-to-back: start in DONE, done pulses 6 cycles apart
    repeat (2) begin @(posedge clk); #1; end
    e.z = 32'hA000_0000; e.count = 5'd2; e.zero = 1'b0;
    issue(32'h2800_0000, 1'b0, e);
    wait_done(5, t1);
    e.z = 32'h8000_0000; e.count = 5'd24; e.zero = 1'b0;
    issue(32'hFFFF_FF80, 1'b1, e);
    wait_done(5, t2);
    chk("done_spacing", t2 - t1, 6);

    // Reset during S4 drops the operation
    repeat (2) begin @(posedge clk); #1; end
    e = model(32'h0001_0000, 1'b0);
    issue(32'h0001_0000, 1'b0, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    void'(q.pop_back());
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_z", z, 32'd0);
    chk("mid_rst_count", {27'd0, count}, 32'd0);
    chk("mid_rst_zero", {31'd0, zero}, 32'd0);
    repeat (8) begin @(posedge clk); #1; end
    run_dir(32'h0001_0000, 1'b0, 32'h8000_0000, 5'd15, 1'b0);

    // Random sweep against the reference model
    for (int n = 0; n < 60; n++) begin
      av = $urandom >> $urandom_range(0, 31);
      cv = 1'($urandom_range(0, 1));
      if (cv && ($urandom_range(0, 1) == 1)) av = ~av;
      issue(av, cv, model(av, cv));
      wait_done(5, t1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
